// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic ops plus an iterative unsigned multiplier
// (MUL low half, MULH high half), with valid/ready handshakes on both sides.
module alu_mc #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_BPC = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_flags,
    output logic             busy
);

    localparam int unsigned STEPS = WIDTH / MUL_BPC;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ORR  = 3'b011;
    localparam logic [2:0] OP_BPS  = 3'b100;

    logic [1:0]         r_state, w_state_nxt;
    logic [2*WIDTH-1:0] r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic               r_mulh, w_mulh_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic [3:0]         r_flags, w_flags_nxt;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_addsub;
    logic [WIDTH-1:0]   w_b_eff;
    logic [WIDTH:0]     w_sum;
    logic               w_carry;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_alu_res;
    logic [3:0]         w_alu_flags;
    logic [2*WIDTH-1:0] w_pp;
    logic [2*WIDTH-1:0] w_acc_step;
    logic               w_last;
    logic [WIDTH-1:0]   w_mul_res;

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_MUL);
    assign result    = r_result;
    assign alu_flags = r_flags;

    assign w_accept    = in_valid & in_ready;
    assign w_is_mul    = (alu_control[2:1] == 2'b11);
    assign w_is_addsub = (alu_control[2:1] == 2'b00);

    // SUB is a + ~b + 1, so carry-out of 1 means no borrow.
    assign w_b_eff = alu_control[0] ? ~b : b;
    assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, alu_control[0]};
    assign w_carry = w_is_addsub & w_sum[WIDTH];
    assign w_ovf   = w_is_addsub & ~(a[WIDTH-1] ^ w_b_eff[WIDTH-1])
                                 & (a[WIDTH-1] ^ w_sum[WIDTH-1]);

    always_comb begin
        w_alu_res = '0;
        case (alu_control)
            OP_ADD,
            OP_SUB:  w_alu_res = w_sum[WIDTH-1:0];
            OP_AND:  w_alu_res = a & b;
            OP_ORR:  w_alu_res = a | b;
            OP_BPS:  w_alu_res = b;
            default: w_alu_res = '0;
        endcase
    end

    assign w_alu_flags = {w_alu_res[WIDTH-1], (w_alu_res == '0), w_carry, w_ovf};

    // One shift-add step: add the multiplicand for each set bit of the low MUL_BPC
    // multiplier bits; the multiplicand is pre-shifted so the step count needs no decode.
    always_comb begin
        w_pp = '0;
        for (int unsigned j = 0; j < MUL_BPC; j++) begin
            if (r_mplier[j]) begin
                w_pp = w_pp + (r_mcand << j);
            end
        end
    end

    assign w_acc_step = r_acc + w_pp;
    assign w_last     = (r_cnt == CW'(STEPS - 1));
    assign w_mul_res  = r_mulh ? w_acc_step[2*WIDTH-1:WIDTH] : w_acc_step[WIDTH-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_mulh_nxt   = r_mulh;
        w_result_nxt = r_result;
        w_flags_nxt  = r_flags;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_nxt  = S_MUL;
                        w_mcand_nxt  = {{WIDTH{1'b0}}, a};
                        w_mplier_nxt = b;
                        w_acc_nxt    = '0;
                        w_cnt_nxt    = '0;
                        w_mulh_nxt   = ~alu_control[0];
                    end else begin
                        w_state_nxt  = S_DONE;
                        w_result_nxt = w_alu_res;
                        w_flags_nxt  = w_alu_flags;
                    end
                end else if ((r_state == S_DONE) && out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL: begin
                w_acc_nxt    = w_acc_step;
                w_mcand_nxt  = r_mcand << MUL_BPC;
                w_mplier_nxt = r_mplier >> MUL_BPC;
                w_cnt_nxt    = r_cnt + CW'(1);
                if (w_last) begin
                    w_state_nxt  = S_DONE;
                    w_result_nxt = w_mul_res;
                    w_flags_nxt  = {w_mul_res[WIDTH-1], (w_mul_res == '0), 2'b00};
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mulh   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mulh   <= w_mulh_nxt;
            r_result <= w_result_nxt;
            r_flags  <= w_flags_nxt;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed cases on a 32/2 instance, then randomized ops with
// back-pressure on 32/2, 16/1 and 16/4 instances against an arithmetic reference model.
module tb_alu_mc;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu_control;
    int          sel;

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic        bz0, bz1, bz2;
    logic [31:0] res0;
    logic [15:0] res1, res2;
    logic [3:0]  fl0, fl1, fl2;

    logic        m_in_ready, m_out_valid, m_busy;
    logic [31:0] m_result;
    logic [3:0]  m_flags;

    int          tests = 0;
    int          fails = 0;
    int          cur_w = 32;
    int          cur_bpc = 2;
    logic [31:0] exp_r;
    logic [3:0]  exp_f;
    int          exp_lat;

    alu_mc #(.WIDTH(32), .MUL_BPC(2)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid && sel == 0), .in_ready(rdy0),
        .a(a), .b(b), .alu_control(alu_control), .out_valid(ov0), .out_ready(out_ready),
        .result(res0), .alu_flags(fl0), .busy(bz0)
    );
    alu_mc #(.WIDTH(16), .MUL_BPC(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid && sel == 1), .in_ready(rdy1),
        .a(a[15:0]), .b(b[15:0]), .alu_control(alu_control), .out_valid(ov1),
        .out_ready(out_ready), .result(res1), .alu_flags(fl1), .busy(bz1)
    );
    alu_mc #(.WIDTH(16), .MUL_BPC(4)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid && sel == 2), .in_ready(rdy2),
        .a(a[15:0]), .b(b[15:0]), .alu_control(alu_control), .out_valid(ov2),
        .out_ready(out_ready), .result(res2), .alu_flags(fl2), .busy(bz2)
    );

    always_comb begin
        m_in_ready  = rdy0;
        m_out_valid = ov0;
        m_busy      = bz0;
        m_result    = res0;
        m_flags     = fl0;
        if (sel == 1) begin
            m_in_ready = rdy1; m_out_valid = ov1; m_busy = bz1;
            m_result = {16'd0, res1}; m_flags = fl1;
        end else if (sel == 2) begin
            m_in_ready = rdy2; m_out_valid = ov2; m_busy = bz2;
            m_result = {16'd0, res2}; m_flags = fl2;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Returns {N,Z,C,V,result} from plain wide arithmetic on width-w unsigned/signed values.
    function automatic logic [35:0] model(input int w, input logic [31:0] ia, input logic [31:0] ib,
                                          input logic [2:0] op);
        longint unsigned mask, ua, ub, r, p;
        longint          sa, sb, ss, smax, smin;
        bit              c, v;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, ia} & mask;
        ub   = {32'd0, ib} & mask;
        sa   = ((ua >> (w - 1)) != 0) ? longint'(ua) - longint'(mask) - 1 : longint'(ua);
        sb   = ((ub >> (w - 1)) != 0) ? longint'(ub) - longint'(mask) - 1 : longint'(ub);
        smax = longint'(mask >> 1);
        smin = -smax - 1;
        c = 1'b0; v = 1'b0; r = 0; p = 0;
        case (op)
            3'd0: begin
                r = (ua + ub) & mask; c = (ua + ub) > mask;
                ss = sa + sb; v = (ss > smax) || (ss < smin);
            end
            3'd1: begin
                r = (ua - ub) & mask; c = (ua >= ub);
                ss = sa - sb; v = (ss > smax) || (ss < smin);
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ub;
            3'd6: begin p = ua * ub; r = p >> w; end
            3'd7: begin p = ua * ub; r = p & mask; end
            default: r = 0;
        endcase
        return {((r >> (w - 1)) & 64'd1) != 0, r == 0, c, v, r[31:0]};
    endfunction

    // Present an op while idle (or on a take cycle) and let it be accepted.
    task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic [2:0] op);
        logic [35:0] m;
        m       = model(cur_w, xa, xb, op);
        exp_r   = m[31:0];
        exp_f   = m[35:32];
        exp_lat = (op[2:1] == 2'b11) ? cur_w / cur_bpc + 1 : 1;
        a = xa; b = xb; alu_control = op; in_valid = 1'b1;
        #1 check("in_ready_accept", 64'(m_in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        a = $urandom; b = $urandom; alu_control = 3'($urandom_range(0, 7));
    endtask

    // Wait (bounded) for out_valid, check latency/busy/result, then stall for 'holds' cycles.
    task automatic collect(input int holds);
        int cyc = 1;
        int busy_cyc = 0;
        while (!m_out_valid && cyc < exp_lat + 4) begin
            if (m_busy) busy_cyc++;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("latency", 64'(cyc), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cyc), 64'(exp_lat - 1));
        check("result", 64'(m_result), 64'(exp_r));
        check("flags", 64'(m_flags), 64'(exp_f));
        check("busy_done", 64'(m_busy), 64'd0);
        for (int i = 0; i < holds; i++) begin
            in_valid = 1'b1;
            alu_control = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            #1 check("stall_in_ready", 64'(m_in_ready), 64'd0);
            @(negedge clk);
            check("stall_valid", 64'(m_out_valid), 64'd1);
            check("stall_result", 64'(m_result), 64'(exp_r));
            check("stall_flags", 64'(m_flags), 64'(exp_f));
        end
        in_valid = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        #1 check("take_in_ready", 64'(m_in_ready), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        #1 check("after_take_valid", 64'(m_out_valid), 64'd0);
    endtask

    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic [2:0] op,
                          input int holds);
        issue(xa, xb, op);
        collect(holds);
        take();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_8000;
            3: return 32'h7FFF_7FFF;
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic random_phase(input int which, input int w, input int bpc, input int n);
        sel = which; cur_w = w; cur_bpc = bpc;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            run_op(pick(), pick(), 3'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end
    endtask

    initial begin
        sel = 0; reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; alu_control = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(m_out_valid), 64'd0);
        check("rst_busy", 64'(m_busy), 64'd0);
        check("rst_result", 64'(m_result), 64'd0);
        check("rst_flags", 64'(m_flags), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        #1 check("rst_in_ready", 64'(m_in_ready), 64'd1);

        run_op(32'h7FFF_FFFF, 32'h1, 3'd0, 0);
        check("add_ovf_res", 64'(res0), 64'h8000_0000);
        run_op(32'h7FFF_FFFF, 32'h1, 3'd0, 0);
        issue(32'd5, 32'd5, 3'd1);
        collect(0);
        check("sub_zero_flags", 64'(fl0), 64'h6);
        take();
        issue(32'hF0, 32'h0F, 3'd3);
        collect(0);
        check("orr_res", 64'(res0), 64'hFF);
        take();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7);
        collect(0);
        check("mul_ones_res", 64'(res0), 64'h1);
        take();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd6);
        collect(0);
        check("mulh_ones_res", 64'(res0), 64'hFFFF_FFFE);
        check("mulh_ones_flags", 64'(fl0), 64'h8);
        take();
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 3'd5, 0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 3'd4, 0);
        run_op(32'hDEAD_BEEF, 32'hFFFF_0000, 3'd2, 0);
        run_op(32'h0, 32'hFFFF_FFFF, 3'd7, 0);

        // Stall an ADD for 5 cycles, then take it while accepting MUL 3*4 in the same cycle.
        issue(32'd10, 32'd20, 3'd0);
        collect(5);
        out_ready = 1'b1;
        issue(32'd3, 32'd4, 3'd7);
        check("b2b_busy", 64'(m_busy), 64'd1);
        check("b2b_valid", 64'(m_out_valid), 64'd0);
        collect(0);
        check("b2b_mul_res", 64'(res0), 64'd12);
        take();

        // Reset in the middle of a multiply discards it.
        issue(32'hFFFF_FFFF, 32'h1234_5678, 3'd7);
        repeat (7) @(negedge clk);
        check("pre_rst_busy", 64'(m_busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(m_out_valid), 64'd0);
        check("mid_rst_busy", 64'(m_busy), 64'd0);
        check("mid_rst_result", 64'(m_result), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("post_rst_in_ready", 64'(m_in_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("post_rst_no_valid", 64'(m_out_valid), 64'd0);
        run_op(32'd2, 32'd2, 3'd0, 0);
        check("post_rst_add", 64'(res0), 64'd4);

        random_phase(0, 32, 2, 300);
        random_phase(1, 16, 1, 1200);
        random_phase(2, 16, 4, 1500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
